iobuf_bank_sync: RTL
====================

Name: iobuf_bank_sync

Overview:
- Parametrised, clocked successor to the single-bit tri-state I/O buffer cell.
- Drives a bank of WIDTH bidirectional pads from a registered output path and a registered tri-state control.
- Enforces a programmable high-Z turnaround window before the bank drives, to avoid bus contention.
- Returns pad values through an optional synchroniser chain; used at board-level bidirectional buses (e.g. shared data lines) in the library.

Parameters:
- WIDTH, 8: number of pad channels sharing one direction control; legal range 1 to 64.
- TURN_CYCLES, 2: number of high-Z clock cycles inserted between a drive request and actual drive; legal range 0 to 15.
- SYNC_STAGES, 2: number of flops on the pad-to-O input path; legal range 0 to 4. 0 means O follows IO combinationally.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- I  input  WIDTH  data to be driven onto the pads.
- T  input  1  tri-state request; 1 = release (high-Z), 0 = request drive. Same sense as the single-bit cell.
- IO  inout  WIDTH  pads.
- O  output  WIDTH  pad value returned to the core.
- DRV  output  1  1 while the bank actively drives IO.
- BUSY  output  1  1 while a turnaround is in progress.

Behaviour:
- Reset (RST_N low, asynchronous): state = HIZ, IO = all z, output data register = 0, all sync flops = 0, O = 0 (SYNC_STAGES > 0), DRV = 0, BUSY = 0, turnaround counter = 0.
- Reset is effective immediately, including mid-turnaround or mid-drive. The pads release with no clock edge required.
- Output data register loads I on every rising edge, in all states. Latency from I to IO is 1 cycle while in DRIVE.
- State machine, with T sampled at the rising edge:
  - HIZ: IO = z, DRV = 0, BUSY = 0.
    - T = 0 and TURN_CYCLES = 0: go to DRIVE.
    - T = 0 and TURN_CYCLES > 0: go to TURN, counter loaded with TURN_CYCLES - 1.
    - T = 1: stay in HIZ.
  - TURN: IO = z, DRV = 0, BUSY = 1.
    - T = 1: abort to HIZ (counter cleared).
    - Otherwise, counter = 0: go to DRIVE.
    - Otherwise: decrement counter.
  - DRIVE: IO = output data register, DRV = 1, BUSY = 0.
    - T = 1: go to HIZ at that edge. Release is never delayed.
    - T = 0: stay in DRIVE.
- Timing: T falls before edge k, with T held low. Then IO is first driven after edge k + TURN_CYCLES, and DRV rises after the same edge.
- Re-drive after any release always repeats the full turnaround. There is no shortcut.
- All outputs (IO enable, DRV, BUSY) are decoded from registered state only, so there are no combinational paths from T.
- Input path:
  - SYNC_STAGES = N > 0: O is IO delayed by N rising edges through a flop chain, sampled in all states. O therefore reflects the bank's own driven data during DRIVE.
  - SYNC_STAGES = 0: O = IO combinationally.
- Counter width is 4 bits. An out-of-range parameter is a compile-time error.

Optional Feature:
- Macro IOBUF_BANK_SYNC_KEEPER_EN.
- When defined: the first input-sync flop of each channel holds its previous value whenever the sampled pad bit is z or x. This emulates a weak bus keeper, so O never shows z or x after the first stage.
  - With SYNC_STAGES = 0, O bits that are z or x are replaced by the last value seen on a rising edge. This costs one keeper flop per bit.
- When not defined: z or x propagates through the sync chain unchanged.

Test Plan:
- Reset hold: RST_N = 0 with T = 0, I = 8'hA5 -> IO = z, O = 0, DRV = 0, BUSY = 0. Assert RST_N low during DRIVE -> IO goes z immediately, with no clock edge.
- Turnaround (TURN_CYCLES = 2, WIDTH = 8, I = 8'h3C): drop T before edge 0 -> BUSY = 1 after edges 0 and 1; IO = 8'h3C and DRV = 1 after edge 2; O = 8'h3C after edge 4 (SYNC_STAGES = 2).
- Abort: T low at edge 0, T high at edge 1 (TURN_CYCLES = 3) -> state HIZ after edge 1, IO never driven, BUSY = 0. Then T low again -> a full 3-cycle turnaround restarts.
- Immediate release and re-drive: in DRIVE, raise T at edge n -> IO = z and DRV = 0 after edge n. Lower T at edge n+1 -> drive resumes after edge n+3 (TURN_CYCLES = 2), not earlier.
- TURN_CYCLES = 0, SYNC_STAGES = 0: T low at edge 0 with I = 8'hFF -> IO = 8'hFF after edge 0, and O = 8'hFF in the same cycle (combinational).
- Keeper: with IOBUF_BANK_SYNC_KEEPER_EN defined, drive 8'h5A, then release with no external driver -> O stays 8'h5A indefinitely. Without the macro -> O becomes z after 2 edges.

Source files
------------

// File: rtl/iobuf_bank_sync.sv
// Clocked WIDTH-bit tri-state pad bank with high-Z turnaround and input sync.
// Optional: IOBUF_BANK_SYNC_KEEPER_EN models a weak keeper on the input path.
module iobuf_bank_sync #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  inout  wire  [WIDTH-1:0] IO,
  output logic [WIDTH-1:0] O,
  output logic             DRV,
  output logic             BUSY
);

  if (WIDTH < 1 || WIDTH > 64 ||
      TURN_CYCLES < 0 || TURN_CYCLES > 15 ||
      SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_param
    $error("iobuf_bank_sync: parameter out of range");
  end

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [3:0] TURN_LOAD =
    (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;
  localparam bit NO_TURN = (TURN_CYCLES == 0);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HIZ;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= I;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HIZ: begin
        if (!T) begin
          if (NO_TURN) begin
            state_d = DRIVE;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (T) begin
          state_d = HIZ;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DRIVE: begin
        if (T) state_d = HIZ;
      end
      default: begin
        state_d = HIZ;
        cnt_d   = '0;
      end
    endcase
  end

  // Pad enable is decoded from registered state only; reset releases at once.
  assign DRV  = (state_q == DRIVE);
  assign BUSY = (state_q == TURN);
  assign IO   = DRV ? dout_q : {WIDTH{1'bz}};

  if (SYNC_STAGES == 0) begin : g_comb
`ifdef IOBUF_BANK_SYNC_KEEPER_EN
    logic [WIDTH-1:0] keep_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        keep_q <= '0;
      end else begin
        for (int b = 0; b < WIDTH; b++) begin
          if (!$isunknown(IO[b])) keep_q[b] <= IO[b];
        end
      end
    end

    always_comb begin
      O = IO;
      for (int b = 0; b < WIDTH; b++) begin
        if ($isunknown(IO[b])) O[b] = keep_q[b];
      end
    end
`else
    assign O = IO;
`endif
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] first_d;

    always_comb begin
      first_d = IO;
`ifdef IOBUF_BANK_SYNC_KEEPER_EN
      for (int b = 0; b < WIDTH; b++) begin
        if ($isunknown(IO[b])) first_d[b] = sync_q[0][b];
      end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= first_d;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign O = sync_q[SYNC_STAGES-1];
  end

endmodule
